// File: rtl/spi_master_global_pkg.sv
// rtl/spi_master_global_pkg.sv - shared constants, FSM state type and length helpers for the SPI master
// Contents:
//   NO_OF_SLAVES  default number of active-low chip selects
//   DATA_WIDTH    maximum bits per transfer (fixed at 32)
//   spi_state_e   engine FSM states
//   eff_len       maps a raw 6-bit length request to 1..DATA_WIDTH
//   beat_count    number of sclk beats for a length in single or quad mode
package spi_master_global_pkg;

    localparam int NO_OF_SLAVES = 1;
    localparam int DATA_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } spi_state_e;

    // A length of zero, or anything beyond the word size, means a full word.
    function automatic logic [5:0] eff_len(input logic [5:0] len);
        if (len == 6'd0 || len > 6'(DATA_WIDTH)) begin
            return 6'(DATA_WIDTH);
        end
        return len;
    endfunction

    // Quad mode moves a nibble per beat, rounding a partial nibble up.
    function automatic logic [5:0] beat_count(input logic [5:0] len, input logic quad);
        logic [5:0] padded;
        padded = len + 6'd3;
        return quad ? (padded >> 2) : len;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - sclk divider producing phase ticks and sclk edge strobes
// Ports:
//   clk_i          system clock (pclk), rising edge
//   reset_i        synchronous active-high reset
//   run_i          divider counts while high, held at zero otherwise
//   shift_i        sclk toggles on each tick while high, forced low otherwise
//   tick_o         last pclk cycle of a CLK_DIV-long phase
//   rise_strobe_o  this pclk edge takes sclk 0->1
//   fall_strobe_o  this pclk edge takes sclk 1->0
//   sclk_o         registered SPI clock
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic shift_i,
    output logic tick_o,
    output logic rise_strobe_o,
    output logic fall_strobe_o,
    output logic sclk_o
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;

    assign tick_o        = run_i && (cnt_q == TERM);
    assign rise_strobe_o = tick_o && shift_i && !sclk_q;
    assign fall_strobe_o = tick_o && shift_i && sclk_q;
    assign sclk_o        = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        // Reload at the terminal count; the increment guard keeps the
        // counter from ever running past it.
        if (!run_i || tick_o) begin
            cnt_d = '0;
        end else if (cnt_q < TERM) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (!shift_i) begin
            sclk_d = 1'b0;
        end else if (tick_o) begin
            sclk_d = !sclk_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - single/quad SPI master (mode 0) with command handshake
// Ports:
//   pclk, areset             clock and synchronous active-high reset
//   tx_valid/tx_ready        command handshake; accepted when both high
//   tx_data, tx_len          word and bit count (0 or >32 means 32), MSB-first
//   tx_quad, tx_slave        quad mode select and chip-select index
//   rx_data, rx_valid        right-justified received bits, one-cycle pulse
//   busy                     high from acceptance until back in IDLE
//   sclk, cs                 SPI clock (CPOL=0, CPHA=0), active-low selects
//   mosi0..3, miso0..3       data lines (only index 0 used in single mode)
module spi_master_engine #(
    parameter int  NO_OF_SLAVES = spi_master_global_pkg::NO_OF_SLAVES,
    parameter int  CLK_DIV      = 4,
    parameter int  DATA_WIDTH   = spi_master_global_pkg::DATA_WIDTH,
    localparam int SLV_W        = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    input  logic [5:0]              tx_len,
    input  logic                    tx_quad,
    input  logic [SLV_W-1:0]        tx_slave,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic                    rx_valid,
    output logic                    busy,
    output logic                    sclk,
    output logic [NO_OF_SLAVES-1:0] cs,
    output logic                    mosi0,
    output logic                    mosi1,
    output logic                    mosi2,
    output logic                    mosi3,
    input  logic                    miso0,
    input  logic                    miso1,
    input  logic                    miso2,
    input  logic                    miso3
);

    typedef spi_master_global_pkg::spi_state_e state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   sh_q, sh_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [5:0]              beats_q, beats_d;
    logic [5:0]              beat_q, beat_d;
    logic                    quad_q, quad_d;
    logic [SLV_W-1:0]        slave_q, slave_d;

    logic                    tick;
    logic                    rise_strobe;
    logic                    fall_strobe;
    logic                    accept;
    logic [5:0]              len_eff;

    assign tx_ready = (state_q == spi_master_global_pkg::IDLE) && !areset;
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_q != spi_master_global_pkg::IDLE);
    assign len_eff  = spi_master_global_pkg::eff_len(tx_len);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk_i        (pclk),
        .reset_i      (areset),
        .run_i        (busy),
        .shift_i      (state_q == spi_master_global_pkg::SHIFT),
        .tick_o       (tick),
        .rise_strobe_o(rise_strobe),
        .fall_strobe_o(fall_strobe),
        .sclk_o       (sclk)
    );

    // rx_valid lands in the last CS_HOLD cycle so that tx_ready rises the
    // cycle after it and the cs-low window covers the whole hold phase.
    assign rx_valid = (state_q == spi_master_global_pkg::CS_HOLD) && tick && !areset;
    assign rx_data  = rx_q;

    // The transmit word is kept left-aligned so the outgoing bit/nibble is
    // always at the top; unused low bits shift in as zero padding.
    assign mosi0 = busy && (quad_q ? sh_q[DATA_WIDTH-4] : sh_q[DATA_WIDTH-1]);
    assign mosi1 = busy && quad_q && sh_q[DATA_WIDTH-3];
    assign mosi2 = busy && quad_q && sh_q[DATA_WIDTH-2];
    assign mosi3 = busy && quad_q && sh_q[DATA_WIDTH-1];

    // An out-of-range slave index matches no select, so the transfer runs
    // with every cs left high.
    for (genvar i = 0; i < NO_OF_SLAVES; i++) begin : g_cs
        assign cs[i] = !(busy && (slave_q == SLV_W'(i)));
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        beats_d = beats_q;
        beat_d  = beat_q;
        quad_d  = quad_q;
        slave_d = slave_q;
        case (state_q)
            spi_master_global_pkg::IDLE: begin
                if (accept) begin
                    state_d = spi_master_global_pkg::CS_SETUP;
                    sh_d    = tx_data << (6'(DATA_WIDTH) - len_eff);
                    rx_d    = '0;
                    beats_d = spi_master_global_pkg::beat_count(len_eff, tx_quad);
                    beat_d  = '0;
                    quad_d  = tx_quad;
                    slave_d = tx_slave;
                end
            end
            spi_master_global_pkg::CS_SETUP: begin
                if (tick) begin
                    state_d = spi_master_global_pkg::SHIFT;
                end
            end
            spi_master_global_pkg::SHIFT: begin
                if (rise_strobe) begin
                    rx_d = quad_q ? {rx_q[DATA_WIDTH-5:0], miso3, miso2, miso1, miso0}
                                  : {rx_q[DATA_WIDTH-2:0], miso0};
                end
                if (fall_strobe) begin
                    sh_d = quad_q ? (sh_q << 4) : (sh_q << 1);
                    // The beat counter stops at the last beat instead of
                    // wrapping; the state change ends the shift phase.
                    if (beat_q == beats_q - 6'd1) begin
                        state_d = spi_master_global_pkg::CS_HOLD;
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            spi_master_global_pkg::CS_HOLD: begin
                if (tick) begin
                    state_d = spi_master_global_pkg::IDLE;
                end
            end
            default: begin
                state_d = spi_master_global_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q <= spi_master_global_pkg::IDLE;
            sh_q    <= '0;
            rx_q    <= '0;
            beats_q <= '0;
            beat_q  <= '0;
            quad_q  <= 1'b0;
            slave_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            beats_q <= beats_d;
            beat_q  <= beat_d;
            quad_q  <= quad_d;
            slave_q <= slave_d;
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - directed self-checking bench for spi_master_engine
module tb_spi_master_engine;

    localparam int NS = 3;

    logic          pclk     = 1'b0;
    logic          areset   = 1'b1;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [31:0]   tx_data  = '0;
    logic [5:0]    tx_len   = '0;
    logic          tx_quad  = 1'b0;
    logic [1:0]    tx_slave = '0;
    logic [31:0]   rx_data;
    logic          rx_valid;
    logic          busy;
    logic          sclk;
    logic [NS-1:0] cs;
    logic          mosi0, mosi1, mosi2, mosi3;
    logic          miso0, miso1, miso2, miso3;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master_engine #(
        .NO_OF_SLAVES(NS),
        .CLK_DIV     (2)
    ) dut (
        .pclk    (pclk),
        .areset  (areset),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .tx_len  (tx_len),
        .tx_quad (tx_quad),
        .tx_slave(tx_slave),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .sclk    (sclk),
        .cs      (cs),
        .mosi0   (mosi0),
        .mosi1   (mosi1),
        .mosi2   (mosi2),
        .mosi3   (mosi3),
        .miso0   (miso0),
        .miso1   (miso1),
        .miso2   (miso2),
        .miso3   (miso3)
    );

    always #5 pclk = ~pclk;

    // Slave model: echo pattern left-aligned, advanced by the number of
    // sclk rising edges seen since the transfer started.
    logic        quad_m    = 1'b0;
    logic [31:0] slv_left  = '0;
    int          rise_base = 0;
    int          rise_cnt  = 0;
    logic [31:0] mcap      = '0;
    logic [31:0] slv_cur;

    assign slv_cur = slv_left << (quad_m ? 4 * (rise_cnt - rise_base) : (rise_cnt - rise_base));
    assign miso0   = quad_m ? slv_cur[28] : slv_cur[31];
    assign miso1   = quad_m & slv_cur[29];
    assign miso2   = quad_m & slv_cur[30];
    assign miso3   = quad_m & slv_cur[31];

    always @(posedge sclk) begin
        rise_cnt <= rise_cnt + 1;
        mcap     <= quad_m ? {mcap[27:0], mosi3, mosi2, mosi1, mosi0} : {mcap[30:0], mosi0};
    end

    int cs_lo [NS];
    int rxv_cnt = 0;

    always @(negedge pclk) begin
        for (int k = 0; k < NS; k++) begin
            if (cs[k] === 1'b0) cs_lo[k] <= cs_lo[k] + 1;
        end
        if (rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;
    end

    int base_lo [NS];
    int base_rxv;

    task automatic start_xfer(input logic [31:0] d, input logic [5:0] len, input logic q,
                              input logic [1:0] s, input logic [31:0] echo, input int ebits);
        slv_left  = echo << (32 - ebits);
        quad_m    = q;
        rise_base = rise_cnt;
        for (int k = 0; k < NS; k++) base_lo[k] = cs_lo[k];
        base_rxv  = rxv_cnt;
        @(negedge pclk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_len   = len;
        tx_quad  = q;
        tx_slave = s;
        for (int i = 0; i < 50; i++) begin
            if (tx_ready) break;
            @(negedge pclk);
        end
        @(negedge pclk);
        // Scramble inputs after acceptance; the engine must ignore them.
        tx_valid = 1'b0;
        tx_data  = 32'hFFFF_FFFF;
        tx_len   = 6'd5;
        tx_quad  = ~q;
        tx_slave = ~s;
    endtask

    task automatic wait_done(output bit ok, output logic [31:0] rxd);
        ok  = 1'b0;
        rxd = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge pclk);
            if (rx_valid) begin
                ok  = 1'b1;
                rxd = rx_data;
                break;
            end
        end
        @(negedge pclk);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge pclk);
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready_in_reset: got %b want 0", tx_ready); end
        n_checks++; if (cs !== 3'b111) begin n_fail++; $display("FAIL reset_cs: got %b want 111", cs); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
        n_checks++; if ({mosi3, mosi2, mosi1, mosi0} !== 4'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0000", {mosi3, mosi2, mosi1, mosi0}); end
        areset = 1'b0;
        @(negedge pclk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready_after: got %b want 1", tx_ready); end
    endtask

    task automatic test_single_basic();
        bit ok; logic [31:0] rxd;
        start_xfer(32'h0000_00A5, 6'd8, 1'b0, 2'd0, 32'h3C, 8);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_done(ok, rxd);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done: got no rx_valid want pulse"); end
        n_checks++; if (rxd !== 32'h0000_003C) begin n_fail++; $display("FAIL single_rx: got %h want 0000003c", rxd); end
        n_checks++; if (mcap[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_mosi: got %h want a5", mcap[7:0]); end
        n_checks++; if (rise_cnt - rise_base !== 8) begin n_fail++; $display("FAIL single_rises: got %0d want 8", rise_cnt - rise_base); end
        n_checks++; if (cs_lo[0] - base_lo[0] !== 36) begin n_fail++; $display("FAIL single_cs_low: got %0d want 36", cs_lo[0] - base_lo[0]); end
        n_checks++; if (cs_lo[1] - base_lo[1] + cs_lo[2] - base_lo[2] !== 0) begin n_fail++; $display("FAIL single_other_cs: got %0d want 0", cs_lo[1] - base_lo[1] + cs_lo[2] - base_lo[2]); end
        n_checks++; if (rxv_cnt - base_rxv !== 1) begin n_fail++; $display("FAIL single_rxv_count: got %0d want 1", rxv_cnt - base_rxv); end
        n_checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got ready=%b busy=%b want 1 0", tx_ready, busy); end
    endtask

    task automatic test_quad_full();
        bit ok; logic [31:0] rxd;
        start_xfer(32'h1234_5678, 6'd32, 1'b1, 2'd1, 32'hDEAD_BEEF, 32);
        wait_done(ok, rxd);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL quad_done: got no rx_valid want pulse"); end
        n_checks++; if (rxd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL quad_rx: got %h want deadbeef", rxd); end
        n_checks++; if (mcap !== 32'h1234_5678) begin n_fail++; $display("FAIL quad_mosi: got %h want 12345678", mcap); end
        n_checks++; if (rise_cnt - rise_base !== 8) begin n_fail++; $display("FAIL quad_beats: got %0d want 8", rise_cnt - rise_base); end
        n_checks++; if (cs_lo[1] - base_lo[1] !== 36) begin n_fail++; $display("FAIL quad_cs1_low: got %0d want 36", cs_lo[1] - base_lo[1]); end
        n_checks++; if (cs_lo[0] - base_lo[0] !== 0) begin n_fail++; $display("FAIL quad_cs0: got %0d want 0", cs_lo[0] - base_lo[0]); end
    endtask

    task automatic test_len_boundaries();
        bit ok; logic [31:0] rxd;
        start_xfer(32'h8000_0001, 6'd0, 1'b0, 2'd0, 32'h0F0F_0F0F, 32);
        wait_done(ok, rxd);
        n_checks++; if (rxd !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL len0_rx: got %h want 0f0f0f0f", rxd); end
        n_checks++; if (mcap !== 32'h8000_0001) begin n_fail++; $display("FAIL len0_mosi: got %h want 80000001", mcap); end
        n_checks++; if (rise_cnt - rise_base !== 32) begin n_fail++; $display("FAIL len0_rises: got %0d want 32", rise_cnt - rise_base); end
        n_checks++; if (cs_lo[0] - base_lo[0] !== 132) begin n_fail++; $display("FAIL len0_cs_low: got %0d want 132", cs_lo[0] - base_lo[0]); end

        start_xfer(32'hFFFF_FF2D, 6'd6, 1'b1, 2'd0, 32'hC7, 8);
        wait_done(ok, rxd);
        n_checks++; if (rxd !== 32'h0000_00C7) begin n_fail++; $display("FAIL len6q_rx: got %h want 000000c7", rxd); end
        n_checks++; if (mcap[7:0] !== 8'hB4) begin n_fail++; $display("FAIL len6q_mosi: got %h want b4", mcap[7:0]); end
        n_checks++; if (rise_cnt - rise_base !== 2) begin n_fail++; $display("FAIL len6q_beats: got %0d want 2", rise_cnt - rise_base); end
        n_checks++; if (cs_lo[0] - base_lo[0] !== 12) begin n_fail++; $display("FAIL len6q_cs_low: got %0d want 12", cs_lo[0] - base_lo[0]); end

        start_xfer(32'h0000_0003, 6'd40, 1'b0, 2'd0, 32'hAAAA_5555, 32);
        wait_done(ok, rxd);
        n_checks++; if (rise_cnt - rise_base !== 32) begin n_fail++; $display("FAIL len40_rises: got %0d want 32", rise_cnt - rise_base); end
        n_checks++; if (rxd !== 32'hAAAA_5555) begin n_fail++; $display("FAIL len40_rx: got %h want aaaa5555", rxd); end

        start_xfer(32'h0000_0001, 6'd1, 1'b0, 2'd0, 32'h1, 1);
        wait_done(ok, rxd);
        n_checks++; if (rxd !== 32'h0000_0001) begin n_fail++; $display("FAIL len1_rx: got %h want 00000001", rxd); end
        n_checks++; if (rise_cnt - rise_base !== 1 || mcap[0] !== 1'b1) begin n_fail++; $display("FAIL len1_shift: got rises=%0d bit=%b want 1 1", rise_cnt - rise_base, mcap[0]); end
        n_checks++; if (cs_lo[0] - base_lo[0] !== 8) begin n_fail++; $display("FAIL len1_cs_low: got %0d want 8", cs_lo[0] - base_lo[0]); end
    endtask

    task automatic test_slave_select();
        bit ok; logic [31:0] rxd;
        start_xfer(32'h9, 6'd4, 1'b0, 2'd2, 32'h6, 4);
        wait_done(ok, rxd);
        n_checks++; if (cs_lo[2] - base_lo[2] !== 20) begin n_fail++; $display("FAIL slv2_cs2_low: got %0d want 20", cs_lo[2] - base_lo[2]); end
        n_checks++; if (cs_lo[0] - base_lo[0] + cs_lo[1] - base_lo[1] !== 0) begin n_fail++; $display("FAIL slv2_others: got %0d want 0", cs_lo[0] - base_lo[0] + cs_lo[1] - base_lo[1]); end
        n_checks++; if (rxd !== 32'h6) begin n_fail++; $display("FAIL slv2_rx: got %h want 00000006", rxd); end

        start_xfer(32'h9, 6'd4, 1'b0, 2'd3, 32'h5, 4);
        wait_done(ok, rxd);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL slv3_done: got no rx_valid want pulse"); end
        n_checks++; if (cs_lo[0] - base_lo[0] + cs_lo[1] - base_lo[1] + cs_lo[2] - base_lo[2] !== 0) begin n_fail++; $display("FAIL slv3_no_cs: got %0d want 0", cs_lo[0] - base_lo[0] + cs_lo[1] - base_lo[1] + cs_lo[2] - base_lo[2]); end
        n_checks++; if (rise_cnt - rise_base !== 4 || rxd !== 32'h5) begin n_fail++; $display("FAIL slv3_timing: got rises=%0d rx=%h want 4 00000005", rise_cnt - rise_base, rxd); end
    endtask

    task automatic test_reset_mid();
        bit ok; bit hit; logic [31:0] rxd;
        int rxv0;
        start_xfer(32'h1234_5678, 6'd32, 1'b1, 2'd0, 32'hDEAD_BEEF, 32);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rise_cnt - rise_base == 3) begin hit = 1'b1; break; end
            @(negedge pclk);
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach_beat3: got timeout want beat 3"); end
        rxv0 = rxv_cnt;
        areset = 1'b1;
        @(negedge pclk);
        n_checks++; if (cs !== 3'b111 || sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_lines: got cs=%b sclk=%b want 111 0", cs, sclk); end
        n_checks++; if (busy !== 1'b0 || rx_data !== 32'h0 || {mosi3, mosi2, mosi1, mosi0} !== 4'b0) begin n_fail++; $display("FAIL rstmid_state: got busy=%b rx=%h mosi=%b want 0 0 0", busy, rx_data, {mosi3, mosi2, mosi1, mosi0}); end
        areset = 1'b0;
        repeat (40) @(negedge pclk);
        n_checks++; if (rxv_cnt !== rxv0) begin n_fail++; $display("FAIL rstmid_no_rxv: got %0d pulses want 0", rxv_cnt - rxv0); end
        start_xfer(32'h0000_00A5, 6'd8, 1'b0, 2'd0, 32'h3C, 8);
        wait_done(ok, rxd);
        n_checks++; if (!ok || rxd !== 32'h3C) begin n_fail++; $display("FAIL rstmid_recover: got ok=%b rx=%h want 1 0000003c", ok, rxd); end
        n_checks++; if (cs_lo[0] - base_lo[0] !== 36) begin n_fail++; $display("FAIL rstmid_recover_cs: got %0d want 36", cs_lo[0] - base_lo[0]); end
    endtask

    task automatic test_back_to_back();
        int nacc, nrx, acc1, acc2, rx1;
        nacc = 0; nrx = 0; acc1 = -1; acc2 = -1; rx1 = -1;
        quad_m    = 1'b0;
        slv_left  = '0;
        rise_base = rise_cnt;
        @(negedge pclk);
        tx_valid = 1'b1;
        tx_data  = 32'h5;
        tx_len   = 6'd4;
        tx_quad  = 1'b0;
        tx_slave = 2'd0;
        for (int c = 0; c < 300; c++) begin
            if (tx_ready) begin
                nacc++;
                if (nacc == 1) acc1 = c;
                if (nacc == 2) acc2 = c;
            end
            if (rx_valid) begin
                nrx++;
                if (nrx == 1) rx1 = c;
            end
            if (nrx >= 2) break;
            @(negedge pclk);
        end
        tx_valid = 1'b0;
        n_checks++; if (nrx !== 2) begin n_fail++; $display("FAIL b2b_rx_count: got %0d want 2", nrx); end
        n_checks++; if (nacc !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", nacc); end
        n_checks++; if (rx1 - acc1 !== 20) begin n_fail++; $display("FAIL b2b_first_len: got %0d want 20", rx1 - acc1); end
        n_checks++; if (acc2 - rx1 !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", acc2 - rx1); end
        repeat (30) @(negedge pclk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_basic();
        test_quad_full();
        test_len_boundaries();
        test_slave_select();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_engine.md
SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 Parameter NO_OF_SLAVES, default 1 from shared package: number of active-low chip selects.
REQ-002 Parameter CLK_DIV, default 4: sclk half-period in pclk cycles; legal range 1..255.
REQ-003 Parameter DATA_WIDTH, fixed at 32: maximum bits per transfer.
REQ-004 pclk  in  1  sole clock; all logic on rising edge.
REQ-005 areset  in  1  reset; synchronous, active-high.
REQ-006 tx_valid  in  1  command valid.
REQ-007 tx_ready  out  1  engine idle, command accepted this cycle if tx_valid.
REQ-008 tx_data  in  32  transmit word; MSB-first from bit (len-1).
REQ-009 tx_len  in  6  bits to transfer: 1..32; 0 or >32 means 32.
REQ-010 tx_quad  in  1  0 = single mode (mosi0/miso0); 1 = quad mode (4 bits per sclk).
REQ-011 tx_slave  in  max(1,$clog2(NO_OF_SLAVES))  chip-select index.
REQ-012 rx_data  out  32  received bits, right-justified, upper bits zero.
REQ-013 rx_valid  out  1  one-cycle pulse, rx_data valid.
REQ-014 busy  out  1  high from acceptance until return to IDLE.
REQ-015 sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-016 cs  out  NO_OF_SLAVES  active-low chip selects.
REQ-017 mosi0..mosi3  out  1 each  master-out lines.
REQ-018 miso0..miso3  in  1 each  master-in lines.

Function
REQ-019 FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD; tx_ready = (state==IDLE) && !areset.
REQ-020 IDLE->CS_SETUP on tx_valid&&tx_ready; tx_data, effective length, tx_quad and tx_slave latched in that cycle; later input changes ignored.
REQ-021 CS_SETUP: cs[tx_slave] low, sclk low, first bit(s) on mosi; lasts CLK_DIV cycles, then SHIFT.
REQ-022 SHIFT: per beat, sclk low CLK_DIV cycles then high CLK_DIV cycles; miso sampled on the pclk edge where sclk goes 0->1; next mosi bit(s) driven on the edge where sclk goes 1->0.
REQ-023 Single mode: beats = len; mosi0 carries tx_data[len-1] first; mosi1..3 held 0; miso0 shifted into rx LSB.
REQ-024 Quad mode: beats = ceil(len/4); each beat mosi3..mosi0 = next nibble MSB-first, zero-padded below bit 0 when len not a multiple of 4; miso3..miso0 shifted in as nibble; rx_data = 4*beats received bits.
REQ-025 After final high phase, CS_HOLD: sclk low, cs still low, CLK_DIV cycles; then cs all high, rx_valid pulses 1 cycle, state IDLE.
REQ-026 Total cs-low time = CLK_DIV*(2 + 2*beats) pclk cycles; tx_ready returns high the cycle after rx_valid.
REQ-027 tx_slave >= NO_OF_SLAVES: transfer runs with full timing, all cs stay high, rx_valid still pulses.
REQ-028 tx_valid during busy: ignored, not queued.
REQ-029 Bit and divider counters saturate at terminal count; no wrap during a transfer.

Reset
REQ-030 areset high at any pclk edge, including mid-transfer: next state IDLE, sclk=0, cs all 1, mosi0..3=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1 after release; partial transfer discarded, no rx_valid.

Structure
REQ-031 NO_OF_SLAVES, DATA_WIDTH and the FSM state enum typedef reside in shared package spi_master_global_pkg.
REQ-032 sclk divider/edge strobes in one sub-module spi_sclk_gen (outputs rise_strobe, fall_strobe, sclk); shift and FSM in spi_master_engine.

Verification
REQ-033 CLK_DIV=2, single, len=8, tx_data=0xA5, slave echo 0x3C on miso0 -> mosi0 bits 1,0,1,0,0,1,0,1; rx_data=0x0000003C; cs low 36 cycles.
REQ-034 Quad, len=32, tx_data=0x12345678, miso nibbles 0xDEADBEEF -> 8 sclk beats, mosi nibbles 1..8, rx_data=0xDEADBEEF.
REQ-035 tx_len=0, single -> 32 sclk rising edges; tx_len=6 quad -> 2 beats, second nibble zero-padded, rx_data 8 bits.
REQ-036 areset asserted at beat 3 of 8 -> next cycle cs all high, sclk 0, no rx_valid; next command completes normally.
REQ-037 NO_OF_SLAVES=4, tx_slave=2 -> only cs[2] low; tx_slave=5 (3-bit field) impossible, tx_slave=3 with NO_OF_SLAVES=3 -> no cs low, rx_valid pulses.
REQ-038 tx_valid held high across busy -> exactly one transfer per tx_ready handshake, back-to-back with one IDLE cycle between.
